pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, elastic pipeline-stage register for the core datapath (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle between stages, using a valid/ready handshake, an optional skid entry, synchronous flush-to-bubble, and a saturating stall counter. It replaces the fixed-field, always-capture stage registers and adds backpressure, bubble insertion and reset.

## Interface
- DATA_W, 128: data payload width (PC, operands, immediate, shamt, register indices, ...).
- CTRL_W, 24: control bundle width. All-zero encodes NOP.
- SKID, 1: 1 = two-entry skid buffer (full throughput, registered in_ready); 0 = single entry.
- CNT_W, 16: stall counter width.

- Clk  in  1  clock, rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream stage presents a valid instruction.
- in_ready  out  1  this stage can accept this cycle.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  DATA_W  data bundle.
- flush  in  1  synchronous kill of all held and incoming entries.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream consumes this cycle.
- out_ctrl  out  CTRL_W  control bundle; forced 0 when out_valid=0.
- out_data  out  DATA_W  data bundle; unchanged on bubble.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0. Saturates at all-ones.

## Operation
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- Storage: main entry M (drives outputs). When SKID=1, also skid entry S.
- SKID=1 states (M.valid, S.valid): EMPTY(0,0), ONE(1,0), FULL(1,1).
  - EMPTY: accept -> ONE.
  - ONE: accept & transfer -> ONE (M reloaded). Accept & no transfer -> FULL (input into S). Transfer & no accept -> EMPTY.
  - FULL: in_ready=0. Transfer -> ONE, S moves into M. No transfer -> hold.
  - in_ready = !S.valid. This is a registered signal, with no combinational path from out_ready.
- SKID=0: in_ready = !M.valid | out_ready (combinational). Accept loads M. Transfer without accept clears M.valid.
- Flush has priority over everything in the same cycle.
  - Next state EMPTY: M.valid=S.valid=0, and the stored ctrl of M and S is zeroed.
  - The incoming entry is discarded even if in_valid & in_ready.
  - The data fields of M and S are not cleared.
- out_ctrl = M.valid ? M.ctrl : 0, so a bubble is always a NOP to the consumer.
- stall_cnt increments each cycle with out_valid & !out_ready & !flush. It holds at 2^CNT_W-1, and clears only on reset.
- in_valid may drop without an accept. The stage does not require upstream to hold.

## Timing
- Latency: 1 cycle from accept to out_valid, from EMPTY or from ONE with a simultaneous transfer.
- Throughput: 1 entry per cycle under continuous out_ready, for both SKID values.
- Reset (async assert, sync deassert by the system):
  - out_valid=0, M.valid=S.valid=0, in_ready=1.
  - out_ctrl=0, out_data=0, stall_cnt=0.
- Reset asserted mid-transfer drops all entries immediately, without waiting for a clock edge.
- The first accept is possible on the first rising edge after Rst_n=1.
- Flush takes effect at the edge where it is sampled. The next cycle shows out_valid=0 and in_ready=1.

## Structure
- The shared package pipe_pkg holds:
  - CTRL_NOP (all-zero) and the per-stage CTRL_W constants.
  - The ctrl field layout typedefs (RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUShift, jump, j_jrSrc, ReadSp, ALUOp[5:0], whb[1:0]).
  - The per-stage DATA_W constants.
- Sub-module pipe_skid_entry is a single valid+ctrl+data register with load, clear-ctrl and clear-valid. It is instanced once for M and, under SKID=1, once for S.

## Test plan
- Reset: assert Rst_n=0 mid-stream with M and S full. Required: out_valid, out_ctrl, out_data and stall_cnt read 0 within the same cycle, and in_ready=1.
- Streaming, SKID=1: 8 back-to-back accepts with out_ready=1, data=i. Required: out_data 0..7 on consecutive cycles, starting 1 cycle after the first accept, and in_ready always 1.
- Backpressure: out_ready=0 for 3 cycles while feeding A, B, C.
  - Required: A is held on the outputs and B goes to S.
  - in_ready=0 after B, so C is not accepted.
  - stall_cnt=3.
  - out_ready=1 then yields A, B, C in order, with no loss or duplication.
- Flush in FULL with in_valid=1 and ctrl=0xFFFFFF. Required: next cycle out_valid=0, out_ctrl=0, in_ready=1, and no entry emerges later.
- SKID=0: out_ready toggling 1,0,1,0 with continuous in_valid. Required:
  - in_ready mirrors !out_valid|out_ready combinationally.
  - Order is preserved.
  - stall_cnt increments only in out_ready=0 cycles with out_valid=1.
- Saturation with CNT_W=4: 20 stalled cycles. Required: stall_cnt=15 and holds.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: constants and control-bundle layout shared by the core pipeline stage registers.
package pipe_pkg;

  // Control bundle carried from decode onward; an all-zero bundle is a NOP.
  typedef struct packed {
    logic [5:0] rsvd;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       ALUSrc;
    logic       RegDst;
    logic       ALUShift;
    logic       jump;
    logic       j_jrSrc;
    logic       ReadSp;
    logic [5:0] ALUOp;
    logic [1:0] whb;
  } ctrl_t;

  localparam int CTRL_W_FULL  = $bits(ctrl_t);

  // Control widths per stage boundary.
  localparam int CTRL_W_IFID  = CTRL_W_FULL;
  localparam int CTRL_W_IDEX  = CTRL_W_FULL;
  localparam int CTRL_W_EXMEM = CTRL_W_FULL;
  localparam int CTRL_W_MEMWB = CTRL_W_FULL;

  // Data widths per stage boundary (PC, operands, immediate, shamt, register indices).
  localparam int DATA_W_IFID  = 64;
  localparam int DATA_W_IDEX  = 128;
  localparam int DATA_W_EXMEM = 128;
  localparam int DATA_W_MEMWB = 96;

  localparam logic [CTRL_W_FULL-1:0] CTRL_NOP = '0;

  // Occupancy of the stage, encoded as {skid valid, main valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_t;

  // True when a control bundle carries no side effects.
  function automatic logic ctrl_is_nop(input ctrl_t c);
    return c == ctrl_t'(CTRL_NOP);
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: one valid+ctrl+data holding register with load, clear-ctrl and clear-valid.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 128
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic              clr_valid,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Valid flag: a clear wins over a load so a kill can never be overridden.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid <= 1'b0;
    end else if (clr_valid) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Control field: zeroing it on a kill keeps a stale bundle from ever looking live.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ctrl <= '0;
    end else if (clr_ctrl) begin
      ctrl <= '0;
    end else if (load) begin
      ctrl <= ld_ctrl;
    end
  end

  // Data field: only written on load, a kill leaves it as it was.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= ld_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with valid/ready, optional skid entry,
// flush-to-bubble and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 24,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_t      state;
  stage_state_t      state_nxt;

  logic              accept;
  logic              xfer;

  logic              m_load;
  logic              m_from_s;
  logic              m_clr_valid;
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ld_ctrl;
  logic [DATA_W-1:0] m_ld_data;

  logic              s_load;
  logic              s_clr_valid;
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  assign accept = in_valid & in_ready;
  assign xfer   = m_valid & out_ready;

  // With a skid entry, ready depends only on a flop; without it, a consuming
  // downstream frees the single entry in the same cycle.
  generate
    if (SKID != 0) begin : g_rdy_skid
      assign in_ready = !s_valid;
    end else begin : g_rdy_single
      assign in_ready = !m_valid | out_ready;
    end
  endgenerate

  // Occupancy register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next occupancy and entry controls; flush overrides every other event.
  always_comb begin
    state_nxt   = state;
    m_load      = 1'b0;
    m_from_s    = 1'b0;
    m_clr_valid = 1'b0;
    s_load      = 1'b0;
    s_clr_valid = 1'b0;
    if (flush) begin
      state_nxt   = ST_EMPTY;
      m_clr_valid = 1'b1;
      s_clr_valid = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_load    = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && xfer) begin
            m_load = 1'b1;
          end else if (accept && (SKID != 0)) begin
            s_load    = 1'b1;
            state_nxt = ST_FULL;
          end else if (xfer) begin
            m_clr_valid = 1'b1;
            state_nxt   = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            m_load      = 1'b1;
            m_from_s    = 1'b1;
            s_clr_valid = 1'b1;
            state_nxt   = ST_ONE;
          end
        end
        default: begin
          state_nxt   = ST_EMPTY;
          m_clr_valid = 1'b1;
          s_clr_valid = 1'b1;
        end
      endcase
    end
  end

  // The main entry refills from the skid entry when draining FULL, else from upstream.
  assign m_ld_ctrl = m_from_s ? s_ctrl : in_ctrl;
  assign m_ld_data = m_from_s ? s_data : in_data;

  pipe_skid_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .load      (m_load),
    .clr_ctrl  (flush),
    .clr_valid (m_clr_valid),
    .ld_ctrl   (m_ld_ctrl),
    .ld_data   (m_ld_data),
    .valid     (m_valid),
    .ctrl      (m_ctrl),
    .data      (m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .load      (s_load),
        .clr_ctrl  (flush),
        .clr_valid (s_clr_valid),
        .ld_ctrl   (in_ctrl),
        .ld_data   (in_data),
        .valid     (s_valid),
        .ctrl      (s_ctrl),
        .data      (s_data)
      );
    end else begin : g_no_skid
      assign s_valid = 1'b0;
      assign s_ctrl  = '0;
      assign s_data  = '0;
    end
  endgenerate

  // A bubble always presents a NOP control bundle; data is left as last held.
  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;

  // Count cycles where a valid entry is blocked downstream, holding at all-ones.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
    end else if (m_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: table vectors plus scoreboard for the skid (A, C) and single-entry (B) stages.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 24;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  typedef struct {
    logic          iv;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic          ordy;
    logic          fl;
    logic          expRdy;
    logic          expVld;
    int            expStall;
  } vec_t;

  logic          Clk;
  logic          Rst_n;

  logic          a_in_valid, a_flush, a_out_ready;
  logic [CW-1:0] a_in_ctrl;
  logic [DW-1:0] a_in_data;
  logic          a_in_ready, a_out_valid;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [15:0]   a_stall;

  logic          c_in_ready, c_out_valid;
  logic [CW-1:0] c_out_ctrl;
  logic [DW-1:0] c_out_data;
  logic [3:0]    c_stall;

  logic          b_in_valid, b_flush, b_out_ready;
  logic [CW-1:0] b_in_ctrl;
  logic [DW-1:0] b_in_data;
  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [15:0]   b_stall;

  int passCnt = 0;
  int checkCnt = 0;

  entry_t sbA[$];
  entry_t sbB[$];
  int stallA = 0;
  int stallC = 0;
  int stallB = 0;

  vec_t vecs[8];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .stall_cnt(a_stall));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dut_c (
    .Clk(Clk), .Rst_n(Rst_n), .in_valid(a_in_valid), .in_ready(c_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .flush(a_flush),
    .out_valid(c_out_valid), .out_ready(a_out_ready), .out_ctrl(c_out_ctrl),
    .out_data(c_out_data), .stall_cnt(c_stall));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .stall_cnt(b_stall));

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One cycle on the skid stages (A and its 4-bit-counter twin C) against the queue model.
  task automatic applyStimulus(input logic iv, input logic [CW-1:0] ctrl, input logic [DW-1:0] data,
                               input logic ordy, input logic fl);
    logic expRdy, expVld, acc, xf;
    entry_t e;
    a_in_valid = iv; a_in_ctrl = ctrl; a_in_data = data; a_out_ready = ordy; a_flush = fl;
    #1;
    expRdy = (sbA.size() < 2);
    expVld = (sbA.size() != 0);
    checkOutput("A in_ready", a_in_ready, expRdy);
    checkOutput("A out_valid", a_out_valid, expVld);
    checkOutput("C in_ready", c_in_ready, expRdy);
    checkOutput("C out_valid", c_out_valid, expVld);
    if (expVld) begin
      checkOutput("A out_ctrl", a_out_ctrl, sbA[0].ctrl);
      checkOutput("A out_data", a_out_data, sbA[0].data);
      checkOutput("C out_ctrl", c_out_ctrl, sbA[0].ctrl);
      checkOutput("C out_data", c_out_data, sbA[0].data);
    end else begin
      checkOutput("A out_ctrl bubble", a_out_ctrl, '0);
    end
    checkOutput("A stall_cnt", a_stall, stallA);
    checkOutput("C stall_cnt", c_stall, stallC);
    acc = iv & expRdy;
    xf  = expVld & ordy;
    if (expVld && !ordy && !fl) begin
      if (stallA < 65535) stallA++;
      if (stallC < 15) stallC++;
    end
    if (fl) sbA.delete();
    else begin
      if (xf) void'(sbA.pop_front());
      if (acc) begin
        e.ctrl = ctrl; e.data = data;
        sbA.push_back(e);
      end
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // One cycle on the single-entry stage B against its queue model.
  task automatic applyStimulusB(input logic iv, input logic [CW-1:0] ctrl, input logic [DW-1:0] data,
                                input logic ordy, input logic fl);
    logic expRdy, expVld, acc, xf;
    entry_t e;
    b_in_valid = iv; b_in_ctrl = ctrl; b_in_data = data; b_out_ready = ordy; b_flush = fl;
    #1;
    expVld = (sbB.size() != 0);
    expRdy = !expVld | ordy;
    checkOutput("B in_ready", b_in_ready, expRdy);
    checkOutput("B out_valid", b_out_valid, expVld);
    if (expVld) begin
      checkOutput("B out_ctrl", b_out_ctrl, sbB[0].ctrl);
      checkOutput("B out_data", b_out_data, sbB[0].data);
    end else begin
      checkOutput("B out_ctrl bubble", b_out_ctrl, '0);
    end
    checkOutput("B stall_cnt", b_stall, stallB);
    acc = iv & expRdy;
    xf  = expVld & ordy;
    if (expVld && !ordy && !fl) stallB++;
    if (fl) sbB.delete();
    else begin
      if (xf) void'(sbB.pop_front());
      if (acc) begin
        e.ctrl = ctrl; e.data = data;
        sbB.push_back(e);
      end
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    // Backpressure vectors: A held while B skids, C refused until the stage drains.
    vecs[0] = '{1'b1, 24'h000A01, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[1] = '{1'b1, 24'h000B02, 32'hB, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[2] = '{1'b1, 24'h000C03, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[3] = '{1'b1, 24'h000C03, 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    vecs[4] = '{1'b1, 24'h000C03, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1, 3};
    vecs[5] = '{1'b1, 24'h000C03, 32'hC, 1'b1, 1'b0, 1'b1, 1'b1, 3};
    vecs[6] = '{1'b0, 24'h000000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 3};
    vecs[7] = '{1'b0, 24'h000000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 3};

    a_in_valid = 0; a_in_ctrl = '0; a_in_data = '0; a_flush = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_ctrl = '0; b_in_data = '0; b_flush = 0; b_out_ready = 0;

    // Reset from time zero with a real falling edge.
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    @(negedge Clk);
    checkOutput("reset A out_valid", a_out_valid, 0);
    checkOutput("reset A out_ctrl", a_out_ctrl, 0);
    checkOutput("reset A out_data", a_out_data, 0);
    checkOutput("reset A stall_cnt", a_stall, 0);
    checkOutput("reset A in_ready", a_in_ready, 1);
    checkOutput("reset B in_ready", b_in_ready, 1);
    checkOutput("reset B out_valid", b_out_valid, 0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Backpressure table.
    for (int i = 0; i < 8; i++) begin
      a_in_valid = vecs[i].iv; a_in_ctrl = vecs[i].ctrl; a_in_data = vecs[i].data;
      a_out_ready = vecs[i].ordy; a_flush = vecs[i].fl;
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), a_in_ready, vecs[i].expRdy);
      checkOutput($sformatf("vec%0d out_valid", i), a_out_valid, vecs[i].expVld);
      checkOutput($sformatf("vec%0d stall_cnt", i), a_stall, vecs[i].expStall);
      applyStimulus(vecs[i].iv, vecs[i].ctrl, vecs[i].data, vecs[i].ordy, vecs[i].fl);
    end

    // Streaming: eight back-to-back accepts, one result per cycle.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 24'h010000 + 24'(i), 32'(i), 1'b1, 1'b0);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush in FULL with a live all-ones bundle arriving.
    applyStimulus(1'b1, 24'h000111, 32'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'h000222, 32'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'hFFFFFF, 32'h33, 1'b0, 1'b1);
    checkOutput("flush leaves data", a_out_data, 32'h11);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("A stall after flush", a_stall, 4);

    // Saturation: twenty stalled cycles take the 4-bit counter to all-ones.
    for (int i = 0; i < 21; i++) begin
      applyStimulus(1'b1, 24'h050000 + 24'(i), 32'h500 + 32'(i), 1'b0, 1'b0);
    end
    checkOutput("C stall saturated", c_stall, 15);
    checkOutput("A stall unsaturated", a_stall, 24);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("C stall holds", c_stall, 15);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Reset mid-stream with both entries full, checked before any clock edge.
    applyStimulus(1'b1, 24'h000AAA, 32'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 24'h000BBB, 32'h78, 1'b0, 1'b0);
    a_in_valid = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", a_out_valid, 0);
    checkOutput("async reset out_ctrl", a_out_ctrl, 0);
    checkOutput("async reset out_data", a_out_data, 0);
    checkOutput("async reset stall_cnt", a_stall, 0);
    checkOutput("async reset in_ready", a_in_ready, 1);
    checkOutput("async reset C stall_cnt", c_stall, 0);
    sbA.delete(); stallA = 0; stallC = 0;
    @(negedge Clk);
    Rst_n = 1'b1;

    // Single-entry stage: out_ready toggling under continuous in_valid.
    for (int k = 0; k < 8; k++) begin
      applyStimulusB(1'b1, 24'h020000 + 24'(k), 32'h100 + 32'(k), (k % 2) == 0, 1'b0);
    end
    checkOutput("B stall after toggling", b_stall, 4);
    b_in_valid = 1'b1; b_out_ready = 1'b0;
    #1 checkOutput("B in_ready comb low", b_in_ready, 0);
    b_out_ready = 1'b1;
    #1 checkOutput("B in_ready comb high", b_in_ready, 1);
    applyStimulusB(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulusB(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulusB(1'b1, 24'h000444, 32'h44, 1'b0, 1'b0);
    applyStimulusB(1'b1, 24'hFFFFFF, 32'h45, 1'b1, 1'b1);
    applyStimulusB(1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulusB(1'b0, '0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
